xif_issue_initiator: RTL

- Core-side initiator for the custom-instruction X-interface issue channel; counterpart of the coprocessor-side responder that executes custom opcodes.
- Takes a decoded instruction and operands from the EX stage and drives issue_valid / instr / rs until the coprocessor returns issue_ready.
- On handshake it samples accept / writeback / result and produces a one-cycle register-file write, an illegal-instruction pulse, or a timeout pulse.
- Stalls the pipeline (instr_ready_o low) while an offload is outstanding.

---
 rtl/custom_instr_pkg.sv | 35 +++
 rtl/xif_issue_timer.sv | 38 +++
 rtl/xif_issue_initiator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/custom_instr_pkg.sv
// Shared definitions for the custom-instruction X-interface: offloaded opcode,
// issue FSM states and the registered request/response records.
package custom_instr_pkg;

    localparam logic [6:0] OPCODE_CNTB = 7'b0001011;

    // Storage width for the transaction id; the top uses the low ID_WIDTH bits.
    localparam int unsigned XIF_ID_MAX_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } xif_state_e;

    typedef struct packed {
        logic [XIF_ID_MAX_W-1:0] id;
        logic [31:0]             instr;
        logic [31:0]             rs0;
        logic [31:0]             rs1;
    } xif_req_t;

    typedef struct packed {
        logic        accept;
        logic        writeback;
        logic [4:0]  rd;
        logic [31:0] result;
    } xif_resp_t;

    // Writes to x0 are dropped: an accepted instruction targeting rd=0 has no visible effect.
    function automatic logic rf_write_en(xif_resp_t r);
        return r.accept && r.writeback && (r.rd != 5'd0);
    endfunction

endpackage

// File: rtl/xif_issue_timer.sv
// Issue watchdog: loaded with TIMEOUT-1 when an offload starts, counts down while enabled,
// and flags expiry in the cycle it reaches zero. TIMEOUT=0 removes the watchdog entirely.
module xif_issue_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_i, load_i, en_i};
            assign expire_o      = 1'b0;
        end else begin : g_on
            localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT - 1);

            logic [CntW-1:0] cnt_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (load_i) begin
                    cnt_q <= LoadVal;
                end else if (en_i && (cnt_q != '0)) begin
                    cnt_q <= cnt_q - CntW'(1);
                end
            end

            assign expire_o = en_i && (cnt_q == '0);
        end
    endgenerate

endmodule

// File: rtl/xif_issue_initiator.sv
// Core-side X-interface issue initiator: offloads custom-opcode instructions to a
// coprocessor, stalls EX while outstanding, and turns the response into an rf write or a trap pulse.
module xif_issue_initiator
    import custom_instr_pkg::*;
#(
    parameter logic [6:0]  OPCODE   = OPCODE_CNTB,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    input  logic [31:0]         instr_i,
    input  logic [31:0]         rs0_i,
    input  logic [31:0]         rs1_i,
    output logic                instr_ready_o,
    input  logic                kill_i,
    output logic                issue_valid_o,
    output logic [31:0]         issue_instr_o,
    output logic [31:0]         issue_rs0_o,
    output logic [31:0]         issue_rs1_o,
    output logic [ID_WIDTH-1:0] issue_id_o,
    input  logic                issue_ready_i,
    input  logic                issue_accept_i,
    input  logic                issue_writeback_i,
    input  logic [31:0]         result_i,
    input  logic [4:0]          result_rd_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_waddr_o,
    output logic [31:0]         rf_wdata_o,
    output logic                illegal_o,
    output logic                timeout_o
);

    localparam logic [XIF_ID_MAX_W-1:0] IdMask = XIF_ID_MAX_W'((1 << ID_WIDTH) - 1);

    xif_state_e state_q;
    xif_req_t   req_q;
    xif_resp_t  resp_q;
    logic       issue_valid_q;
    logic       timeout_q;

    logic capture;
    logic expire;
    logic in_resp;
    logic rf_we;

    assign capture = (state_q == StIdle) && instr_valid_i && (instr_i[6:0] == OPCODE) && !kill_i;

    xif_issue_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (capture),
        .en_i     (state_q == StIssue),
        .expire_o (expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            req_q         <= '0;
            resp_q        <= '0;
            issue_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (capture) begin
                        req_q.instr   <= instr_i;
                        req_q.rs0     <= rs0_i;
                        req_q.rs1     <= rs1_i;
                        issue_valid_q <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    // Priority: flush, then handshake, then watchdog.
                    if (kill_i) begin
                        issue_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end else if (issue_ready_i) begin
                        resp_q.accept    <= issue_accept_i;
                        resp_q.writeback <= issue_writeback_i;
                        resp_q.rd        <= result_rd_i;
                        resp_q.result    <= result_i;
                        issue_valid_q    <= 1'b0;
                        state_q          <= StResp;
                    end else if (expire) begin
                        issue_valid_q <= 1'b0;
                        timeout_q     <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                StResp: begin
                    req_q.id <= (req_q.id + XIF_ID_MAX_W'(1)) & IdMask;
                    state_q  <= StIdle;
                end
                default: begin
                    issue_valid_q <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

    assign in_resp = (state_q == StResp) && !kill_i;
    assign rf_we   = in_resp && rf_write_en(resp_q);

    assign instr_ready_o = (state_q == StIdle);
    assign issue_valid_o = issue_valid_q;
    assign issue_instr_o = req_q.instr;
    assign issue_rs0_o   = req_q.rs0;
    assign issue_rs1_o   = req_q.rs1;
    assign issue_id_o    = req_q.id[ID_WIDTH-1:0];
    assign rf_we_o       = rf_we;
    assign rf_waddr_o    = rf_we ? resp_q.rd : 5'd0;
    assign rf_wdata_o    = rf_we ? resp_q.result : 32'd0;
    assign illegal_o     = in_resp && !resp_q.accept;
    assign timeout_o     = timeout_q;

endmodule
